// File: rtl/register_file.sv
// Register file with two combinational read ports, one write port with
// write-first bypass, and a handshaked engine that streams every register.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    output logic [DATA_WIDTH-1:0] read_value_1,
    output logic [DATA_WIDTH-1:0] read_value_2,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_value,
    input  logic                  write_enable,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0] dump_value,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_hit;

    state_t                state;
    state_t                state_n;
    logic                  start_hit;
    logic                  step_hit;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] index_n;
    logic [DATA_WIDTH-1:0] value_n;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_L);
    endfunction

    // Register 0 and out-of-range addresses always read as zero.
    function automatic logic [DATA_WIDTH-1:0] read_view(
        input logic [ADDR_WIDTH-1:0] a
    );
        if (!in_range(a)) begin
            return '0;
        end
        if (write_enable && (write_address == a)) begin
            return write_value;
        end
        return regs[a[IW-1:0]];
    endfunction

    always_comb begin
        wr_hit = write_enable && in_range(write_address);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[write_address[IW-1:0]] <= write_value;
        end
    end

    always_comb begin
        read_value_1 = read_view(read_address_1);
        read_value_2 = read_view(read_address_2);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (dump_start) state_n = STREAM;
            STREAM:  if (dump_ready && (dump_index == LAST)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        dump_valid = (state == STREAM);
        dump_busy  = (state != IDLE);
        dump_done  = (state == DONE);
        start_hit  = (state == IDLE) && dump_start;
        step_hit   = dump_valid && dump_ready && (dump_index != LAST);
        next_addr  = dump_index + 1'b1;
        index_n    = dump_index;
        value_n    = dump_value;
        // Next beat captures the bypassed view, so a same-edge write lands.
        unique case (1'b1)
            start_hit: begin
                index_n = '0;
                value_n = '0;
            end
            step_hit: begin
                index_n = next_addr;
                value_n = read_view(next_addr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dump_index <= '0;
            dump_value <= '0;
        end else begin
            dump_index <= index_n;
            dump_value <= value_n;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: behavioural model checked every
// cycle, plus directed vectors with hand-computed values.
module tb_register_file;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [5:0]  read_address_1;
    logic [5:0]  read_address_2;
    logic [31:0] read_value_1;
    logic [31:0] read_value_2;
    logic [5:0]  write_address;
    logic [31:0] write_value;
    logic        write_enable;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [5:0]  dump_index;
    logic [31:0] dump_value;
    logic        dump_busy;
    logic        dump_done;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    logic [31:0] mregs [32];
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_done = 1'b0;
    int          m_idx = 0;
    logic [31:0] m_val = '0;

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(6),
        .DEPTH(32)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .read_address_1(read_address_1),
        .read_address_2(read_address_2),
        .read_value_1(read_value_1),
        .read_value_2(read_value_2),
        .write_address(write_address),
        .write_value(write_value),
        .write_enable(write_enable),
        .dump_start(dump_start),
        .dump_ready(dump_ready),
        .dump_valid(dump_valid),
        .dump_index(dump_index),
        .dump_value(dump_value),
        .dump_busy(dump_busy),
        .dump_done(dump_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input int a);
        if (a == 0 || a >= 32) return 32'h0;
        if (write_enable && int'(write_address) == a) return write_value;
        return mregs[a];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mregs[i] <= 32'h0;
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            m_idx   <= 0;
            m_val   <= 32'h0;
        end else begin
            if (write_enable && write_address != 0 && write_address < 32)
                mregs[write_address] <= write_value;
            if (m_done) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end else if (!m_busy && dump_start) begin
                m_busy  <= 1'b1;
                m_valid <= 1'b1;
                m_idx   <= 0;
                m_val   <= 32'h0;
            end else if (m_valid && dump_ready) begin
                if (m_idx < 31) begin
                    m_idx <= m_idx + 1;
                    m_val <= mread(m_idx + 1);
                end else begin
                    m_valid <= 1'b0;
                    m_done  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            check("model_rd1", read_value_1, mread(int'(read_address_1)));
            check("model_rd2", read_value_2, mread(int'(read_address_2)));
            check("model_valid", dump_valid, m_valid);
            check("model_busy", dump_busy, m_busy);
            check("model_done", dump_done, m_done);
            check("model_index", dump_index, m_idx[5:0]);
            check("model_value", dump_value, m_val);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_dump(output int n, output int nbeats,
                            output int nonzero, input int restart_at);
        n = 0;
        nbeats = 0;
        nonzero = 0;
        do begin
            @(posedge clock);
            #1;
            dump_start = (n == restart_at);
            @(negedge clock);
            n++;
            if (dump_valid && dump_ready) begin
                nbeats++;
                if (dump_value != int'(dump_index) * 32'h11) nonzero++;
            end
        end while (!dump_done && n < 100);
        dump_start = 1'b0;
    endtask

    initial begin
        int n;
        int nbeats;
        int bad;
        int k;
        write_enable = 1'b0;
        write_address = '0;
        write_value = '0;
        read_address_1 = '0;
        read_address_2 = '0;
        dump_start = 1'b0;
        dump_ready = 1'b1;

        #1 reset_n = 1'b0;
        armed = 1'b1;
        #1;
        check("reset_valid", dump_valid, 1'b0);
        check("reset_busy", dump_busy, 1'b0);
        check("reset_done", dump_done, 1'b0);
        check("reset_index", dump_index, 6'd0);
        check("reset_value", dump_value, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        write_enable = 1'b1;
        write_address = 6'd5;
        write_value = 32'hDEADBEEF;
        step();
        write_address = 6'd31;
        write_value = 32'h1;
        step();
        write_enable = 1'b0;
        read_address_1 = 6'd5;
        read_address_2 = 6'd31;
        @(negedge clock);
        check("rd_r5", read_value_1, 32'hDEADBEEF);
        check("rd_r31", read_value_2, 32'h1);

        step();
        write_enable = 1'b1;
        write_address = 6'd0;
        write_value = 32'h12345678;
        read_address_1 = 6'd0;
        step();
        write_enable = 1'b0;
        @(negedge clock);
        check("rd_r0", read_value_1, 32'h0);

        step();
        write_enable = 1'b1;
        write_address = 6'd40;
        write_value = 32'h87654321;
        read_address_2 = 6'd40;
        step();
        write_enable = 1'b0;
        @(negedge clock);
        check("rd_a40", read_value_2, 32'h0);

        step();
        write_enable = 1'b1;
        write_address = 6'd7;
        write_value = 32'hA5A5A5A5;
        read_address_1 = 6'd7;
        read_address_2 = 6'd7;
        #2;
        check("bypass_rd1", read_value_1, 32'hA5A5A5A5);
        check("bypass_rd2", read_value_2, 32'hA5A5A5A5);

        for (int i = 1; i < 32; i++) begin
            step();
            write_enable = 1'b1;
            write_address = 6'(i);
            write_value = 32'(i) * 32'h11;
        end
        step();
        write_enable = 1'b0;
        read_address_1 = 6'd0;
        read_address_2 = 6'd0;

        dump_ready = 1'b1;
        dump_start = 1'b1;
        run_dump(n, nbeats, bad, 10);
        check("full_done_cycle", 64'(n), 64'd33);
        check("full_beats", 64'(nbeats), 64'd32);
        check("full_values", 64'(bad), 64'd0);
        step();
        @(negedge clock);
        check("full_idle_busy", dump_busy, 1'b0);
        check("full_idle_done", dump_done, 1'b0);

        step();
        read_address_1 = 6'd3;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clock);
            k++;
            if (dump_valid && dump_index == 6'd3) break;
        end
        check("bp_reach3", 64'(k < 20), 64'd1);
        #1 dump_ready = 1'b0;
        step();
        write_enable = 1'b1;
        write_address = 6'd3;
        write_value = 32'hFFFF;
        step();
        write_enable = 1'b0;
        @(negedge clock);
        check("bp_hold_index", dump_index, 6'd3);
        check("bp_hold_value", dump_value, 32'h33);
        check("bp_r3_written", read_value_1, 32'hFFFF);
        step();
        write_enable = 1'b1;
        write_address = 6'd4;
        write_value = 32'hCAFE0004;
        dump_ready = 1'b1;
        @(negedge clock);
        check("bp_pre_accept", dump_value, 32'h33);
        step();
        write_enable = 1'b0;
        @(negedge clock);
        check("bp_beat4_index", dump_index, 6'd4);
        check("bp_beat4_value", dump_value, 32'hCAFE0004);
        k = 0;
        while (!dump_done && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("bp_done_seen", dump_done, 1'b1);

        step();
        read_address_1 = 6'd0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        k = 0;
        while (k < 30) begin
            @(negedge clock);
            k++;
            if (dump_valid && dump_index == 6'd10) break;
        end
        check("rst_reach10", 64'(k < 30), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", dump_valid, 1'b0);
        check("rst_busy", dump_busy, 1'b0);
        check("rst_done", dump_done, 1'b0);
        check("rst_index", dump_index, 6'd0);
        for (int i = 0; i < 32; i++) begin
            read_address_1 = 6'(i);
            read_address_2 = 6'(31 - i);
            #1;
            check("rst_rd1", read_value_1, 32'h0);
            check("rst_rd2", read_value_2, 32'h0);
            check("rst_nodone", dump_done, 1'b0);
        end
        step();
        reset_n = 1'b1;
        read_address_1 = 6'd0;
        read_address_2 = 6'd0;

        step();
        dump_start = 1'b1;
        run_dump(n, nbeats, bad, -1);
        check("post_rst_beats", 64'(nbeats), 64'd32);
        check("post_rst_done", dump_done, 1'b1);
        check("post_rst_value31", dump_value, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
